// File: rtl/fbc_pkg.sv
// Shared types and default timing constants for the PLL feedback conditioner.
// Period limits and the loss-of-signal window are derived from the clock and the legal fb band.
package fbc_pkg;
    typedef enum logic [1:0] {
        NOSIG    = 2'd0,
        ARMED    = 2'd1,
        TRACKING = 2'd2
    } state_e;

    localparam int CLK_HZ       = 50_000_000;
    localparam int FREQ_MIN_HZ  = 50_000;
    localparam int FREQ_MAX_HZ  = 400_000;
    localparam int PERIOD_MIN   = CLK_HZ / FREQ_MAX_HZ;
    localparam int PERIOD_MAX   = CLK_HZ / FREQ_MIN_HZ;
    // Five periods of the slowest legal input without an edge means the signal is gone.
    localparam int NOSIG_CYCLES = 5 * CLK_HZ / FREQ_MIN_HZ;
endpackage

// File: rtl/fb_conditioner_if.sv
// Qualified feedback outputs handed to the phase comparator, frequency loop and display.
interface fb_conditioner_if #(parameter int PERIOD_W = 20);
    logic                fb;
    logic                fb_rise;
    logic                fb_fall;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                period_in_range;
    logic                nosig;
    logic [7:0]          glitch_cnt;

    modport master (output fb, fb_rise, fb_fall, period, period_valid,
                    period_in_range, nosig, glitch_cnt);
    modport slave  (input  fb, fb_rise, fb_fall, period, period_valid,
                    period_in_range, nosig, glitch_cnt);
endinterface

// File: rtl/fb_deglitch.sv
// Synchronizes the raw feedback pin and only lets a level through once it has held
// for GLITCH_CYCLES samples; rejected pulses are counted.
module fb_deglitch #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       fb_u,
    output logic       fb,
    output logic       fb_rise,
    output logic       fb_fall,
    output logic       rise_evt,
    output logic       fall_evt,
    output logic [7:0] glitch_cnt
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             gc_q, gc_d;
    logic [7:0]             glitch_q, glitch_d;
    logic                   fb_q, fb_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], fb_u};
        s        = sync_q[SYNC_STAGES-1];
        gc_d     = gc_q;
        glitch_d = glitch_q;
        fb_d     = fb_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s != fb_q) begin
            if (gc_q == 8'(GLITCH_CYCLES - 1)) begin
                fb_d   = s;
                gc_d   = 8'd0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                gc_d = gc_q + 8'd1;
            end
        end else if (gc_q != 8'd0) begin
            // Input fell back before qualifying: that was a glitch.
            gc_d = 8'd0;
            if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            sync_q   <= '0;
            gc_q     <= 8'd0;
            glitch_q <= 8'd0;
            fb_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            gc_q     <= gc_d;
            glitch_q <= glitch_d;
            fb_q     <= fb_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // Events lead the strobes by one cycle so downstream state lands with the strobe.
    assign rise_evt   = rise_d;
    assign fall_evt   = fall_d;
    assign fb         = fb_q;
    assign fb_rise    = rise_q;
    assign fb_fall    = fall_q;
    assign glitch_cnt = glitch_q;
endmodule

// File: rtl/fb_conditioner.sv
// Feedback front end: deglitched level and strobes, rise-to-rise period measurement
// with range qualification, and loss-of-signal detection.
module fb_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4,
    parameter int PERIOD_W      = 20,
    parameter int PERIOD_MIN    = fbc_pkg::PERIOD_MIN,
    parameter int PERIOD_MAX    = fbc_pkg::PERIOD_MAX,
    parameter int NOSIG_CYCLES  = fbc_pkg::NOSIG_CYCLES
) (
    input  logic                     clk_50,
    input  logic                     rst_n,
    input  logic                     fb_u,
    fb_conditioner_if.master         o
);
    import fbc_pkg::*;

    localparam int AW = $clog2(NOSIG_CYCLES + 1);

    logic                rise_evt, fall_evt, any_evt;
    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pvalid_q, pvalid_d;
    logic                inrange_q, inrange_d;
    logic                nosig_q, nosig_d;
    logic [AW-1:0]       acnt_q, acnt_d;

    fb_deglitch #(
        .SYNC_STAGES   (SYNC_STAGES),
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) u_deglitch (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .fb_u       (fb_u),
        .fb         (o.fb),
        .fb_rise    (o.fb_rise),
        .fb_fall    (o.fb_fall),
        .rise_evt   (rise_evt),
        .fall_evt   (fall_evt),
        .glitch_cnt (o.glitch_cnt)
    );

    assign any_evt = rise_evt | fall_evt;

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        period_d  = period_q;
        pvalid_d  = 1'b0;
        inrange_d = inrange_q;
        nosig_d   = nosig_q;
        acnt_d    = any_evt ? '0 :
                    (acnt_q == AW'(NOSIG_CYCLES)) ? acnt_q : acnt_q + AW'(1);

        if (state_q == NOSIG) begin
            if (rise_evt) begin
                pcnt_d  = PERIOD_W'(1);
                state_d = ARMED;
            end
        end else begin
            // A saturated count lands above PERIOD_MAX, so it reports out of range.
            pcnt_d = (pcnt_q == '1) ? pcnt_q : pcnt_q + PERIOD_W'(1);
            if (rise_evt) begin
                period_d  = pcnt_q;
                pvalid_d  = 1'b1;
                inrange_d = (pcnt_q >= PERIOD_W'(PERIOD_MIN)) &&
                            (pcnt_q <= PERIOD_W'(PERIOD_MAX));
                pcnt_d    = PERIOD_W'(1);
                state_d   = TRACKING;
            end
        end

        // Edges override timeout: acnt_d is already cleared in that case.
        if (any_evt) begin
            nosig_d = 1'b0;
        end else if (acnt_q != AW'(NOSIG_CYCLES) && acnt_d == AW'(NOSIG_CYCLES)) begin
            nosig_d   = 1'b1;
            state_d   = NOSIG;
            inrange_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q   <= NOSIG;
            pcnt_q    <= '0;
            period_q  <= '0;
            pvalid_q  <= 1'b0;
            inrange_q <= 1'b0;
            nosig_q   <= 1'b1;
            acnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            period_q  <= period_d;
            pvalid_q  <= pvalid_d;
            inrange_q <= inrange_d;
            nosig_q   <= nosig_d;
            acnt_q    <= acnt_d;
        end
    end

    assign o.period          = period_q;
    assign o.period_valid    = pvalid_q;
    assign o.period_in_range = inrange_q;
    assign o.nosig           = nosig_q;
endmodule
